// File: rtl/ex_divider.sv
`default_nettype none
// ============================================================================
// Module   : ex_divider
// Purpose  : Iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage.
//            It uses one restoring radix-2 step per cycle, and stalls the
//            pipeline through busy.
// Revision : 1.0
// ============================================================================
module ex_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic             advance,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             sel_rem_q, sel_rem_d;

    // Codes with funct3[2]=0 are not divides and fall through as DIVU.
    logic             w_signed, w_is_rem, w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff, w_rem_step, w_quo_step, w_rem_fix, w_quo_fix;

    assign w_signed = funct3[2] & ~funct3[0];
    assign w_is_rem = funct3[2] & funct3[1];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -a : a;
    assign w_abs_b  = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_ovf    = w_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // The shifted partial remainder needs one extra bit; after a restoring step
    // the kept value is always below the divisor, so WIDTH bits suffice to store it.
    assign w_shift    = {rem_q, quo_q[WIDTH-1]};
    assign w_fits     = (w_shift >= {1'b0, div_q});
    assign w_diff     = w_shift[WIDTH-1:0] - div_q;
    assign w_rem_step = w_fits ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_step = {quo_q[WIDTH-2:0], w_fits};
    assign w_quo_fix  = qneg_q ? -w_quo_step : w_quo_step;
    assign w_rem_fix  = rneg_q ? -w_rem_step : w_rem_step;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        result_d  = result_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy      = 1'b1;
                    sel_rem_d = w_is_rem;
                    qneg_d    = w_a_neg ^ w_b_neg;
                    rneg_d    = w_a_neg;
                    if (w_b_zero) begin
                        result_d = w_is_rem ? a : '1;
                        state_d  = S_DONE;
                    end else if (w_ovf) begin
                        // a is the most negative value here, which is the DIV answer.
                        result_d = w_is_rem ? '0 : a;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = w_abs_a;
                        div_d   = w_abs_b;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                busy  = 1'b1;
                rem_d = w_rem_step;
                quo_d = w_quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = sel_rem_q ? w_rem_fix : w_quo_fix;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (advance) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            result_q  <= result_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
`default_nettype wire

// File: doc/ex_divider.md
Name: ex_divider

Overview:
- Iterative RV32M divide/remainder unit in the EX stage.
- Consumes divider_start and funct3 from the EX-stage control word register, and the rs1/rs2 operands from the EX datapath.
- Produces a 32-bit quotient or remainder.
- Holds the pipeline via busy until the result is ready, then holds the result until the pipeline advances past the instruction.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  divider_start field of the EX control word; stays high while the instruction is stalled in EX.
- funct3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes are treated as DIVU.
- advance  input  1  EX-stage control register load; high in the cycle the pipeline moves past the current instruction.
- a  input  WIDTH  dividend (rs1).
- b  input  WIDTH  divisor (rs2).
- busy  output  1  stall request to hazard control.
- done  output  1  result valid.
- result  output  WIDTH  quotient or remainder.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: clk, rst.
- States: IDLE, CALC, DONE.
- Reset:
  - State becomes IDLE; iteration counter, remainder, quotient and result registers become 0.
  - busy=0, done=0, result=0 in the following cycle.
  - rst overrides every other input, including mid-CALC; the in-flight operation is discarded and no done is produced.
- IDLE:
  - start=0: remain in IDLE.
  - start=1 in cycle T: latch funct3, a and b. For signed ops (funct3[0]=0) latch absolute values and record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
  - Special case b==0: result = 0xFFFFFFFF for DIV/DIVU, result = a for REM/REMU; go to DONE at T+1.
  - Special case signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): result = 0x80000000 for DIV, 0 for REM; go to DONE at T+1.
  - Otherwise load counter = WIDTH and go to CALC at T+1.
- CALC:
  - One restoring radix-2 step per cycle: shift {rem, quo} left by 1; subtract the divisor from rem; if there is no borrow, keep the difference and set quo[0]=1.
  - The remainder datapath is WIDTH+1 bits.
  - Counter decrements each cycle. When it reaches 0 (the WIDTH-th step, cycle T+WIDTH), apply sign correction (two's complement negate per the recorded signs), select quotient or remainder by funct3[1], register it into result, and go to DONE at T+WIDTH+1.
  - start and operand changes are ignored during CALC.
- DONE:
  - done=1 and result is held stable.
  - Remain in DONE while advance=0.
  - advance=1: go to IDLE next cycle. result keeps its value; done drops.
  - A start seen in IDLE after that is a new operation, so back-to-back divides cost one extra cycle.
- busy (combinational): (state==IDLE && start) || state==CALC.
  - busy=0 whenever done=1.
  - Normal latency: busy high for WIDTH+1 cycles (T..T+WIDTH); done first high at T+WIDTH+1.
  - Special-case latency: busy high only at T; done at T+1.
- advance while not in DONE has no effect.

Test Plan:
- Unsigned basic: DIVU a=100, b=7, start held -> busy for 33 cycles, done at T+33, result=14; REMU on the same operands -> result=2.
- Signed with sign correction: DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (-3); REM on the same operands -> result=0xFFFFFFFF (-1).
- Special cases:
  - DIVU a=5, b=0 -> done at T+1, result=0xFFFFFFFF.
  - REM a=0x12345678, b=0 -> result=0x12345678.
  - DIV 0x80000000/0xFFFFFFFF -> result=0x80000000, done at T+1.
- Hold and advance: keep advance=0 for 5 cycles after done -> done and result stable and busy=0 throughout. Pulse advance with start still high (next divide) -> IDLE for one cycle, then the new operation starts with the new operands.
- Reset mid-operation: assert rst at T+10 of DIVU -> next cycle busy=0, done=0, result=0. A subsequent REMU a=9, b=4 completes normally with result=1.
- Randomized: 10k random funct3/a/b with random advance delays -> every result matches the RV32M reference model, and latency is 33 cycles (1 for special cases).
